regwrite_sched: RTL

REGWRITE_SCHED -- requirements
Module: regwrite_sched

---
 rtl/regwrite_sched.sv | 105 ++++++++++
 1 files changed

// File: rtl/regwrite_sched.sv
`default_nettype none
// ============================================================================
//  Module   : regwrite_sched
//  Purpose  : Serialises up to two writebacks per cycle onto a single
//             register-file write port through a circular pending-write
//             FIFO, with a decode-stage lookup over pending entries.
//  Revision : 1.0  initial release
// ============================================================================
module regwrite_sched #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     ctrl_reset,
  input  logic                     in0_valid,
  input  logic [4:0]               in0_reg,
  input  logic [31:0]              in0_data,
  input  logic                     in1_valid,
  input  logic [4:0]               in1_reg,
  input  logic [31:0]              in1_data,
  output logic                     in_ready,
  output logic                     ctrl_writeEnable,
  output logic [4:0]               ctrl_writeReg,
  output logic [31:0]              ctrl_writeData,
  input  logic [4:0]               q_reg,
  output logic                     q_hit,
  output logic [31:0]              q_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [4:0]       ent_reg  [DEPTH];
  logic [31:0]      ent_data [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr_lane1;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] num_push;
  logic             lane_conflict;
  logic             push0;
  logic             push1;
  logic             pop;

  // Acceptance, lane filtering and pointer arithmetic for this edge.
  always_comb begin
    in_ready      = (cnt <= CNT_W'(DEPTH - 2));
    // Same destination on both lanes: the younger lane supersedes the older.
    lane_conflict = in0_valid && in1_valid && (in0_reg == in1_reg);
    push0         = in_ready && in0_valid && (in0_reg != 5'd0) && !lane_conflict;
    push1         = in_ready && in1_valid && (in1_reg != 5'd0);
    num_push      = CNT_W'(push0) + CNT_W'(push1);
    wr_ptr_lane1  = push0 ? (wr_ptr + PTR_W'(1)) : wr_ptr;
    pop           = (cnt != '0);
  end

  // FIFO storage, pointers and occupancy; reset discards every pending entry.
  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_reg[i]  <= '0;
        ent_data[i] <= '0;
      end
    end else begin
      if (push0) begin
        ent_reg[wr_ptr]  <= in0_reg;
        ent_data[wr_ptr] <= in0_data;
      end
      if (push1) begin
        ent_reg[wr_ptr_lane1]  <= in1_reg;
        ent_data[wr_ptr_lane1] <= in1_data;
      end
      wr_ptr <= wr_ptr + PTR_W'(num_push);
      rd_ptr <= rd_ptr + PTR_W'(pop);
      cnt    <= cnt - CNT_W'(pop) + num_push;
    end
  end

  // Write port presents the head entry whenever the FIFO is non-empty.
  always_comb begin
    ctrl_writeEnable = pop;
    ctrl_writeReg    = pop ? ent_reg[rd_ptr]  : 5'd0;
    ctrl_writeData   = pop ? ent_data[rd_ptr] : 32'd0;
    count            = cnt;
  end

  // Lookup walks occupied entries oldest to youngest so the youngest match wins.
  always_comb begin
    q_hit  = 1'b0;
    q_data = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      logic [PTR_W-1:0] idx;
      idx = rd_ptr + PTR_W'(i);
      if ((q_reg != 5'd0) && (CNT_W'(i) < cnt) && (ent_reg[idx] == q_reg)) begin
        q_hit  = 1'b1;
        q_data = ent_data[idx];
      end
    end
  end

endmodule
`default_nettype wire
